// File: rtl/tpu_job_sequencer.sv
// Job sequencer for a TPU: streams A/B/(C) rows from the src buffer onto the TPU bus,
// fires the MatMul command, waits, then copies the 16 C words into the dst buffer.
`timescale 1ns/1ps
module tpu_job_sequencer #(
    parameter int DATAW       = 64,
    parameter int ADDRW       = 16,
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [AW-1:0]    job_src_base,
    input  logic [AW-1:0]    job_dst_base,
    input  logic             job_load_c,
    output logic             busy,
    output logic             done,
    output logic             src_re,
    output logic [AW-1:0]    src_addr,
    input  logic [DATAW-1:0] src_rdata,
    output logic             dst_we,
    output logic [AW-1:0]    dst_addr,
    output logic [DATAW-1:0] dst_wdata,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, READ, DONE} state_t;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [4:0] WAIT_LAST = 5'(WAIT_CYCLES - 1);

    state_t          state_q;
    logic [4:0]      cnt_q;
    logic            prime_q;
    logic [AW-1:0]   src_base_q;
    logic [AW-1:0]   dst_base_q;
    logic            load_c_q;
    logic            src_re_q;
    logic [AW-1:0]   src_addr_q;
    logic            dst_we_q;
    logic [AW-1:0]   dst_addr_q;
    logic            tpu_r_w_q;
    logic [15:0]     tpu_addr_q;
    logic            wr_src_q;
    logic            done_q;
    logic [4:0]      last_word;

    // Word k: 0..7 A rows, 8..15 B rows, 16..31 C half-rows, all 8-byte strided.
    function automatic logic [15:0] word_addr(input logic [4:0] k);
        logic [15:0] base;
        logic [3:0]  idx;
        if (k[4]) begin
            base = 16'h0300;
            idx  = k[3:0];
        end else begin
            base = k[3] ? 16'h0200 : 16'h0100;
            idx  = {1'b0, k[2:0]};
        end
        return base | {9'd0, idx, 3'b000};
    endfunction

    assign last_word = load_c_q ? 5'd31 : 5'd15;

    // Every output register below holds the value for the cycle that follows the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            prime_q    <= 1'b0;
            src_base_q <= '0;
            dst_base_q <= '0;
            load_c_q   <= 1'b0;
            src_re_q   <= 1'b0;
            src_addr_q <= '0;
            dst_we_q   <= 1'b0;
            dst_addr_q <= '0;
            tpu_r_w_q  <= 1'b0;
            tpu_addr_q <= 16'h0000;
            wr_src_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            src_re_q   <= 1'b0;
            src_addr_q <= '0;
            dst_we_q   <= 1'b0;
            dst_addr_q <= '0;
            tpu_r_w_q  <= 1'b0;
            tpu_addr_q <= 16'h0000;
            wr_src_q   <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (job_valid) begin
                        state_q    <= LOAD;
                        cnt_q      <= 5'd0;
                        prime_q    <= 1'b1;
                        src_base_q <= job_src_base;
                        dst_base_q <= job_dst_base;
                        load_c_q   <= job_load_c;
                        src_re_q   <= 1'b1;
                        src_addr_q <= job_src_base;
                    end
                end
                LOAD: begin
                    prime_q <= 1'b0;
                    if (prime_q) begin
                        // First read is in flight; next cycle writes word 0 and reads word 1.
                        tpu_r_w_q  <= 1'b1;
                        wr_src_q   <= 1'b1;
                        tpu_addr_q <= word_addr(5'd0);
                        src_re_q   <= 1'b1;
                        src_addr_q <= src_base_q + AW'(1);
                    end else if (cnt_q == last_word) begin
                        state_q    <= START;
                        cnt_q      <= 5'd0;
                        tpu_r_w_q  <= 1'b1;
                        tpu_addr_q <= 16'h0400;
                    end else begin
                        cnt_q      <= cnt_q + 5'd1;
                        tpu_r_w_q  <= 1'b1;
                        wr_src_q   <= 1'b1;
                        tpu_addr_q <= word_addr(cnt_q + 5'd1);
                        if (cnt_q + 5'd1 != last_word) begin
                            src_re_q   <= 1'b1;
                            src_addr_q <= src_base_q + AW'(cnt_q) + AW'(2);
                        end
                    end
                end
                START: begin
                    cnt_q <= 5'd0;
                    if (HAS_WAIT) begin
                        state_q <= WAIT;
                    end else begin
                        state_q    <= READ;
                        tpu_addr_q <= 16'h0300;
                        dst_we_q   <= 1'b1;
                        dst_addr_q <= dst_base_q;
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q    <= READ;
                        cnt_q      <= 5'd0;
                        tpu_addr_q <= 16'h0300;
                        dst_we_q   <= 1'b1;
                        dst_addr_q <= dst_base_q;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                READ: begin
                    if (cnt_q == 5'd15) begin
                        state_q <= DONE;
                        cnt_q   <= 5'd0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q + 5'd1;
                        tpu_addr_q <= 16'h0300 | {9'd0, cnt_q[3:0] + 4'd1, 3'b000};
                        dst_we_q   <= 1'b1;
                        dst_addr_q <= dst_base_q + AW'(cnt_q) + AW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= 5'd0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 5'd0;
                end
            endcase
        end
    end

    assign job_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign src_re     = src_re_q;
    assign src_addr   = src_addr_q;
    assign dst_we     = dst_we_q;
    assign dst_addr   = dst_addr_q;
    // Data paths are pass-throughs: src read data lands one cycle after its read.
    assign dst_wdata  = dst_we_q ? tpu_dataOut : '0;
    assign tpu_r_w    = tpu_r_w_q;
    assign tpu_addr   = ADDRW'(tpu_addr_q);
    assign tpu_dataIn = wr_src_q ? src_rdata : '0;

endmodule
